rf_arbiter_ctrl: RTL and testbench

Two-requester controller for a 4-entry × 4-bit register bank built from per-bit, select-enabled storage cells. Arbitrates read/write requests from two clients (A, B) with round-robin fairness. Sequences each access through a fixed three-state handshake. Drives the bank's per-register write selects. Sits between the two datapath clients and the register storage, which is owned exclusively by this block.

---
 rtl/rf_arbiter_ctrl_pkg.sv | 23 ++
 rtl/rf_bank4x4.sv | 41 ++++
 rtl/rf_arbiter_ctrl.sv | 140 ++++++++++++++
 tb/tb_rf_arbiter_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rf_arbiter_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_arbiter_ctrl_pkg                                                  |
// | Shared sizes, FSM encodings and client IDs for the arbiter/bank.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rf_arbiter_ctrl_pkg;

  localparam int DEF_DATA_W   = 4;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_ADDR_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic CLI_A = 1'b0;
  localparam logic CLI_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rf_bank4x4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_bank4x4                                                           |
// | Select-enabled register bank with async clear and combinational read.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rf_bank4x4
  import rf_arbiter_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REGS-1:0] i_wsel,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] w_regs [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_q <= '0;
      end else if (i_wsel[i]) begin
        r_q <= i_wdata;
      end
    end

    assign w_regs[i] = r_q;
  end

  assign o_rdata = w_regs[i_addr];

endmodule
`default_nettype wire

// File: rtl/rf_arbiter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_arbiter_ctrl                                                      |
// | Round-robin two-client access controller for a small register bank. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rf_arbiter_ctrl
  import rf_arbiter_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_done,
  output logic              b_done,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy
);

  state_t              r_state;
  logic                r_last;
  logic                r_cli;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NUM_REGS-1:0] r_wsel;
  logic                r_a_gnt, r_b_gnt, r_a_done, r_b_done, r_busy;
  logic [DATA_W-1:0]   r_a_rdata, r_b_rdata;

  logic                w_win;
  logic                w_win_we;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic [DATA_W-1:0]   w_bank_rdata;

  // B takes the slot only when alone, or on a tie when A won last time.
  assign w_win       = (b_req && (!a_req || r_last == CLI_A)) ? CLI_B : CLI_A;
  assign w_win_we    = (w_win == CLI_B) ? b_we    : a_we;
  assign w_win_addr  = (w_win == CLI_B) ? b_addr  : a_addr;
  assign w_win_wdata = (w_win == CLI_B) ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_last    <= CLI_B;
      r_cli     <= CLI_A;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wsel    <= '0;
      r_a_gnt   <= 1'b0;
      r_b_gnt   <= 1'b0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_busy    <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (a_req || b_req) begin
            r_state <= ST_GRANT;
            r_busy  <= 1'b1;
            r_cli   <= w_win;
            r_last  <= w_win;
            r_we    <= w_win_we;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_a_gnt <= (w_win == CLI_A);
            r_b_gnt <= (w_win == CLI_B);
            r_wsel  <= w_win_we ? (NUM_REGS'(1) << w_win_addr) : '0;
          end
        end
        ST_GRANT: begin
          r_state  <= ST_DONE;
          r_a_gnt  <= 1'b0;
          r_b_gnt  <= 1'b0;
          r_wsel   <= '0;
          r_a_done <= (r_cli == CLI_A);
          r_b_done <= (r_cli == CLI_B);
          if (!r_we) begin
            if (r_cli == CLI_A) r_a_rdata <= w_bank_rdata;
            else                r_b_rdata <= w_bank_rdata;
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_a_done <= 1'b0;
          r_b_done <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_a_gnt  <= 1'b0;
          r_b_gnt  <= 1'b0;
          r_a_done <= 1'b0;
          r_b_done <= 1'b0;
          r_wsel   <= '0;
        end
      endcase
    end
  end

  rf_bank4x4 #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .i_wsel  (r_wsel),
    .i_wdata (r_wdata),
    .i_addr  (r_addr),
    .o_rdata (w_bank_rdata)
  );

  assign a_gnt   = r_a_gnt;
  assign b_gnt   = r_b_gnt;
  assign a_done  = r_a_done;
  assign b_done  = r_b_done;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rf_arbiter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rf_arbiter_ctrl                                                   |
// | Directed self-checking bench for rf_arbiter_ctrl.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rf_arbiter_ctrl;
  import rf_arbiter_ctrl_pkg::*;

  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_done, b_done, busy;
  logic [DW-1:0] a_rdata, b_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_arbiter_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .a_gnt   (a_gnt),
    .b_gnt   (b_gnt),
    .a_done  (a_done),
    .b_done  (b_done),
    .a_rdata (a_rdata),
    .b_rdata (b_rdata),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed as {a_gnt, b_gnt, a_done, b_done, busy}.
  task automatic outs(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, a_gnt, b_gnt, a_done, b_done, busy}, {27'd0, exp});
  endtask

  task automatic drive(input logic cli, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    if (cli == CLI_A) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
  endtask

  task automatic idle_all();
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic single(input string tag, input logic cli, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd);
    drive(cli, we, addr, wd);
    @(negedge clk);
    outs({tag, "/gnt"}, (cli == CLI_A) ? 5'b10001 : 5'b01001);
    idle_all();
    @(negedge clk);
    outs({tag, "/done"}, (cli == CLI_A) ? 5'b00101 : 5'b00011);
    if (!we) chk({tag, "/rdata"}, {28'd0, (cli == CLI_A) ? a_rdata : b_rdata}, {28'd0, exp_rd});
    @(negedge clk);
    outs({tag, "/idle"}, 5'b00000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  k, ph;
    logic wb;

    reset = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    // Reset state
    @(negedge clk);
    outs("rst/outs", 5'b00000);
    chk("rst/a_rdata", {28'd0, a_rdata}, 32'd0);
    chk("rst/b_rdata", {28'd0, b_rdata}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    outs("idle/outs", 5'b00000);
    for (int i = 0; i < 4; i++) single($sformatf("rd0_%0d", i), CLI_A, 1'b0, AW'(i), 4'h0, 4'h0);

    // A alone: write then read back; neighbours untouched
    single("wr2", CLI_A, 1'b1, 2'd2, 4'hA, 4'h0);
    single("rd2", CLI_A, 1'b0, 2'd2, 4'h0, 4'hA);
    single("rd0", CLI_A, 1'b0, 2'd0, 4'h0, 4'h0);
    single("rd1", CLI_A, 1'b0, 2'd1, 4'h0, 4'h0);
    single("rd3", CLI_A, 1'b0, 2'd3, 4'h0, 4'h0);
    // Make B the last winner so the next tie goes to A
    single("brd0", CLI_B, 1'b0, 2'd0, 4'h0, 4'h0);

    // Continuous contention: A writes 5 to reg 1, B reads reg 1
    drive(CLI_A, 1'b1, 2'd1, 4'h5);
    drive(CLI_B, 1'b0, 2'd1, 4'h0);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      k  = j / 3;
      ph = j % 3;
      wb = k[0];
      if (ph == 0)      outs($sformatf("rr%0d/gnt", j),  wb ? 5'b01001 : 5'b10001);
      else if (ph == 1) outs($sformatf("rr%0d/done", j), wb ? 5'b00011 : 5'b00101);
      else              outs($sformatf("rr%0d/idle", j), 5'b00000);
      if (ph == 1 && wb) chk($sformatf("rr%0d/b_rdata", j), {28'd0, b_rdata}, 32'd5);
    end
    idle_all();
    chk("rr/a_rdata_kept", {28'd0, a_rdata}, 32'd0);

    // A last winner; B alone wins, A arriving during B's GRANT waits
    single("ard1", CLI_A, 1'b0, 2'd1, 4'h0, 4'h5);
    drive(CLI_B, 1'b0, 2'd2, 4'h0);
    @(negedge clk);
    outs("late/b_gnt", 5'b01001);
    drive(CLI_A, 1'b0, 2'd1, 4'h0);
    @(negedge clk);
    outs("late/b_done", 5'b00011);
    chk("late/b_rdata", {28'd0, b_rdata}, 32'hA);
    b_req = 1'b0;
    @(negedge clk);
    outs("late/idle", 5'b00000);
    @(negedge clk);
    outs("late/a_gnt", 5'b10001);
    a_req = 1'b0;
    @(negedge clk);
    outs("late/a_done", 5'b00101);
    chk("late/a_rdata", {28'd0, a_rdata}, 32'd5);
    @(negedge clk);

    // Input changes during GRANT are ignored
    drive(CLI_A, 1'b1, 2'd0, 4'h3);
    @(negedge clk);
    outs("chg/gnt", 5'b10001);
    a_addr = 2'd3; a_wdata = 4'hF;
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    single("chg_rd0", CLI_A, 1'b0, 2'd0, 4'h0, 4'h3);
    single("chg_rd3", CLI_A, 1'b0, 2'd3, 4'h0, 4'h0);

    // Reset during GRANT of a write: aborted, cleared, pointer back to A
    drive(CLI_A, 1'b1, 2'd0, 4'h7);
    @(negedge clk);
    outs("arst/gnt", 5'b10001);
    #2 reset = 1'b0;
    #1 outs("arst/cleared", 5'b00000);
    chk("arst/a_rdata", {28'd0, a_rdata}, 32'd0);
    idle_all();
    @(negedge clk);
    reset = 1'b1;
    outs("arst/no_done", 5'b00000);
    @(negedge clk);
    outs("arst/still_idle", 5'b00000);
    drive(CLI_A, 1'b0, 2'd0, 4'h0);
    drive(CLI_B, 1'b0, 2'd0, 4'h0);
    @(negedge clk);
    outs("tie/a_gnt", 5'b10001);
    idle_all();
    @(negedge clk);
    outs("tie/a_done", 5'b00101);
    chk("tie/reg0", {28'd0, a_rdata}, 32'd0);
    @(negedge clk);
    outs("tie/idle", 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
